// File: rtl/regfile_arbiter.sv
// Two-requester arbiter in front of a single-write-port register file.
// After reset or a clear request the register file is zero-filled, one
// address per cycle; afterwards requests are served one per cycle with a
// round-robin priority pointer breaking ties. Reads return one cycle later.
module regfile_arbiter #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                clear_req,
  input  logic [1:0]          req_valid,
  input  logic [1:0]          req_write,
  input  logic [2*ADDR_W-1:0] req_addr,
  input  logic [2*DATA_W-1:0] req_wdata,
  output logic [1:0]          req_ready,
  output logic [1:0]          rsp_valid,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                init_done,
  output logic                rf_write_enable,
  output logic [ADDR_W-1:0]   rf_write_addr,
  output logic [DATA_W-1:0]   rf_write_data,
  output logic [ADDR_W-1:0]   rf_read_addr,
  input  logic [DATA_W-1:0]   rf_read_data
);

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};

  state_t            state;
  logic [ADDR_W-1:0] sweep_cnt;
  logic              ptr;
  logic [ADDR_W-1:0] read_addr_hold;

  // Accept-cycle (stage 0) arbitration results
  logic              grant_any_p0;
  logic              grant_idx_p0;
  logic              grant_write_p0;
  logic              grant_read_p0;
  logic [ADDR_W-1:0] grant_addr_p0;
  logic [DATA_W-1:0] grant_wdata_p0;

  // ---- stage 0: arbitration and register-file port drive ----

  // Pick the requester: a lone valid wins, a tie goes to the pointer.
  always_comb begin
    grant_idx_p0 = 1'b0;
    case (req_valid)
      2'b01:   grant_idx_p0 = 1'b0;
      2'b10:   grant_idx_p0 = 1'b1;
      2'b11:   grant_idx_p0 = ptr;
      default: grant_idx_p0 = 1'b0;
    endcase
  end

  // Nothing is accepted while sweeping, in reset, or in a clear cycle.
  assign grant_any_p0   = reset_n && (state == RUN) && !clear_req && (|req_valid);
  assign grant_write_p0 = grant_any_p0 && (grant_idx_p0 ? req_write[1] : req_write[0]);
  assign grant_read_p0  = grant_any_p0 && !grant_write_p0;
  assign grant_addr_p0  = grant_idx_p0 ? req_addr[2*ADDR_W-1:ADDR_W]
                                       : req_addr[ADDR_W-1:0];
  assign grant_wdata_p0 = grant_idx_p0 ? req_wdata[2*DATA_W-1:DATA_W]
                                       : req_wdata[DATA_W-1:0];

  assign req_ready = grant_any_p0 ? (grant_idx_p0 ? 2'b10 : 2'b01) : 2'b00;

  // Write port: sweep zeros in INIT, granted write data in RUN.
  always_comb begin
    rf_write_enable = 1'b0;
    rf_write_addr   = grant_addr_p0;
    rf_write_data   = grant_wdata_p0;
    if (state == INIT) begin
      rf_write_enable = reset_n;
      rf_write_addr   = sweep_cnt;
      rf_write_data   = '0;
    end else begin
      rf_write_enable = grant_write_p0;
    end
  end

  // Read address follows the granted read, otherwise holds the last one.
  assign rf_read_addr = grant_read_p0 ? grant_addr_p0 : read_addr_hold;

  // Control FSM: sweep counter, run/init state, round-robin pointer.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= INIT;
      sweep_cnt <= '0;
      init_done <= 1'b0;
      ptr       <= 1'b0;
    end else begin
      if (grant_any_p0) begin
        ptr <= ~grant_idx_p0;
      end
      case (state)
        INIT: begin
          if (clear_req) begin
            sweep_cnt <= '0;
          end else if (sweep_cnt == LAST_ADDR) begin
            state     <= RUN;
            init_done <= 1'b1;
            sweep_cnt <= '0;
          end else begin
            sweep_cnt <= sweep_cnt + 1'b1;
          end
        end
        RUN: begin
          if (clear_req) begin
            state     <= INIT;
            init_done <= 1'b0;
            sweep_cnt <= '0;
          end
        end
        default: begin
          state <= INIT;
        end
      endcase
    end
  end

  // ---- stage 1: read response register ----

  // Capture read data on the accept edge; the valid pulse lasts one cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rsp_valid      <= 2'b00;
      rsp_rdata      <= '0;
      read_addr_hold <= '0;
    end else begin
      rsp_valid <= 2'b00;
      if (grant_read_p0) begin
        rsp_valid      <= grant_idx_p0 ? 2'b10 : 2'b01;
        rsp_rdata      <= rf_read_data;
        read_addr_hold <= grant_addr_p0;
      end
    end
  end

endmodule

// File: tb/tb_regfile_arbiter.sv
// Bench for regfile_arbiter: directed scenarios plus randomized traffic
// checked against a behavioural model of the sweep, arbitration and memory.
module tb_regfile_arbiter;

  localparam int DW = 8;
  localparam int AW = 4;
  localparam int N  = 16;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          clear_req;
  logic [1:0]    req_valid;
  logic [1:0]    req_write;
  logic [2*AW-1:0] req_addr;
  logic [2*DW-1:0] req_wdata;
  logic [1:0]    req_ready;
  logic [1:0]    rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic          init_done;
  logic          rf_write_enable;
  logic [AW-1:0] rf_write_addr;
  logic [DW-1:0] rf_write_data;
  logic [AW-1:0] rf_read_addr;
  logic [DW-1:0] rf_read_data;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  regfile_arbiter #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk(clk), .reset_n(reset_n), .clear_req(clear_req),
    .req_valid(req_valid), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .init_done(init_done),
    .rf_write_enable(rf_write_enable), .rf_write_addr(rf_write_addr),
    .rf_write_data(rf_write_data), .rf_read_addr(rf_read_addr),
    .rf_read_data(rf_read_data)
  );

  // External register file: synchronous write, combinational read.
  logic [DW-1:0] rf [N];
  always @(posedge clk) if (rf_write_enable) rf[rf_write_addr] <= rf_write_data;
  assign rf_read_data = rf[rf_read_addr];

  // Behavioural model state
  bit            m_run;
  int            m_cnt;
  bit            m_ptr;
  logic [DW-1:0] m_mem [N];
  logic [1:0]    m_rsp_v;
  logic [DW-1:0] m_rsp_d;
  // Model expectations for the current cycle
  logic [1:0]    e_ready;
  logic          e_we;
  logic [AW-1:0] e_waddr;
  logic [DW-1:0] e_wdata;
  logic          e_acc;
  int            e_g;

  task model_reset();
    m_run = 0; m_cnt = 0; m_ptr = 0; m_rsp_v = 2'b00; m_rsp_d = '0;
  endtask

  task model_comb();
    e_ready = 2'b00; e_we = 1'b0; e_waddr = '0; e_wdata = '0; e_acc = 1'b0; e_g = 0;
    if (!reset_n) return;
    if (!m_run) begin
      e_we = 1'b1; e_waddr = m_cnt[AW-1:0]; e_wdata = '0;
      return;
    end
    if (clear_req || req_valid == 2'b00) return;
    if (req_valid == 2'b11) e_g = int'(m_ptr);
    else e_g = req_valid[1] ? 1 : 0;
    e_acc = 1'b1;
    e_ready[e_g] = 1'b1;
    if (req_write[e_g]) begin
      e_we = 1'b1;
      e_waddr = req_addr[e_g*AW +: AW];
      e_wdata = req_wdata[e_g*DW +: DW];
    end
  endtask

  task model_edge();
    logic [1:0] nv;
    nv = 2'b00;
    if (!reset_n) return;
    if (e_acc && !req_write[e_g]) begin
      nv[e_g] = 1'b1;
      m_rsp_d = m_mem[req_addr[e_g*AW +: AW]];
    end
    if (e_we) m_mem[e_waddr] = e_wdata;
    if (e_acc) m_ptr = (e_g == 0);
    if (clear_req) begin
      m_run = 0; m_cnt = 0;
    end else if (!m_run) begin
      if (m_cnt == N-1) begin m_run = 1; m_cnt = 0; end
      else m_cnt++;
    end
    m_rsp_v = nv;
  endtask

  // Cycle phases: tasks run just after the falling edge.
  task drive(input logic clr, input logic [1:0] v, input logic [1:0] w,
             input logic [2*AW-1:0] a, input logic [2*DW-1:0] d);
    clear_req = clr; req_valid = v; req_write = w; req_addr = a; req_wdata = d;
    #1;
    model_comb();
  endtask

  task advance();
    model_edge();
    @(negedge clk);
  endtask

  task do_reset();
    reset_n = 1'b0;
    model_reset();
    drive(1'b0, 2'b00, 2'b00, '0, '0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task test_reset();
    reset_n = 1'b0;
    model_reset();
    drive(1'b0, 2'b11, 2'b01, 8'h21, 16'h1234);
    @(negedge clk);
    @(negedge clk);
    drive(1'b0, 2'b11, 2'b01, 8'h21, 16'h1234);
    n_tests++; if (req_ready !== 2'b00) begin n_fail++; $display("FAIL reset_ready: got %b need 00", req_ready); end
    n_tests++; if (rf_write_enable !== 1'b0) begin n_fail++; $display("FAIL reset_we: got %b need 0", rf_write_enable); end
    n_tests++; if (init_done !== 1'b0) begin n_fail++; $display("FAIL reset_init_done: got %b need 0", init_done); end
    n_tests++; if (rsp_valid !== 2'b00) begin n_fail++; $display("FAIL reset_rsp_valid: got %b need 00", rsp_valid); end
    n_tests++; if (rsp_rdata !== 8'h00) begin n_fail++; $display("FAIL reset_rsp_rdata: got %h need 00", rsp_rdata); end
  endtask

  task test_sweep();
    do_reset();
    for (int i = 0; i < N; i++) begin
      drive(1'b0, 2'($urandom), 2'($urandom), 8'($urandom), 16'($urandom));
      n_tests++; if (rf_write_enable !== 1'b1 || rf_write_addr !== 4'(i) || rf_write_data !== 8'h00) begin
        n_fail++; $display("FAIL sweep_write[%0d]: got we=%b addr=%0d data=%h need we=1 addr=%0d data=00",
                           i, rf_write_enable, rf_write_addr, rf_write_data, i);
      end
      n_tests++; if (req_ready !== 2'b00 || init_done !== 1'b0) begin
        n_fail++; $display("FAIL sweep_idle[%0d]: got ready=%b init_done=%b need 00/0", i, req_ready, init_done);
      end
      advance();
    end
    n_tests++; if (init_done !== 1'b1) begin n_fail++; $display("FAIL sweep_done: got %b need 1 in cycle 17", init_done); end
  endtask

  task test_write_read();
    drive(1'b0, 2'b01, 2'b01, 8'h03, 16'h00A5);
    n_tests++; if (req_ready !== 2'b01 || rf_write_enable !== 1'b1 || rf_write_addr !== 4'd3 || rf_write_data !== 8'hA5) begin
      n_fail++; $display("FAIL wr_accept: got ready=%b we=%b addr=%0d data=%h need 01/1/3/a5",
                         req_ready, rf_write_enable, rf_write_addr, rf_write_data);
    end
    advance();
    drive(1'b0, 2'b01, 2'b00, 8'h03, 16'h0000);
    n_tests++; if (req_ready !== 2'b01 || rf_write_enable !== 1'b0 || rf_read_addr !== 4'd3) begin
      n_fail++; $display("FAIL rd_accept: got ready=%b we=%b raddr=%0d need 01/0/3", req_ready, rf_write_enable, rf_read_addr);
    end
    advance();
    drive(1'b0, 2'b00, 2'b00, 8'h00, 16'h0000);
    n_tests++; if (rsp_valid !== 2'b01 || rsp_rdata !== 8'hA5) begin
      n_fail++; $display("FAIL rd_response: got valid=%b data=%h need 01/a5", rsp_valid, rsp_rdata);
    end
    n_tests++; if (rf_read_addr !== 4'd3) begin n_fail++; $display("FAIL rd_addr_hold: got %0d need 3", rf_read_addr); end
    advance();
    n_tests++; if (rsp_valid !== 2'b00) begin n_fail++; $display("FAIL rd_pulse_end: got %b need 00", rsp_valid); end
  endtask

  task test_round_robin();
    logic [1:0] exp_ready;
    do_reset();
    for (int i = 0; i < N; i++) begin drive(1'b0, 2'b00, 2'b00, '0, '0); advance(); end
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 2'b11, 2'b00, 8'h21, 16'h0000);
      exp_ready = (i % 2 == 0) ? 2'b01 : 2'b10;
      n_tests++; if (req_ready !== exp_ready || rf_read_addr !== ((i % 2 == 0) ? 4'd1 : 4'd2)) begin
        n_fail++; $display("FAIL rr_grant[%0d]: got ready=%b raddr=%0d need %b", i, req_ready, rf_read_addr, exp_ready);
      end
      if (i > 0) begin
        n_tests++; if (rsp_valid !== ~exp_ready || rsp_rdata !== 8'h00) begin
          n_fail++; $display("FAIL rr_rsp[%0d]: got valid=%b data=%h need %b/00", i, rsp_valid, rsp_rdata, ~exp_ready);
        end
      end
      advance();
    end
    drive(1'b0, 2'b00, 2'b00, '0, '0);
    n_tests++; if (rsp_valid !== 2'b10) begin n_fail++; $display("FAIL rr_last_rsp: got %b need 10", rsp_valid); end
    advance();
  endtask

  task test_clear_sweep();
    do_reset();
    for (int i = 0; i < 7; i++) begin drive(1'b0, 2'b00, 2'b00, '0, '0); advance(); end
    drive(1'b1, 2'b00, 2'b00, '0, '0);
    n_tests++; if (rf_write_addr !== 4'd7 || rf_write_enable !== 1'b1) begin
      n_fail++; $display("FAIL clr_cycle8: got we=%b addr=%0d need 1/7", rf_write_enable, rf_write_addr);
    end
    advance();
    for (int i = 0; i < N; i++) begin
      drive(1'b0, 2'b00, 2'b00, '0, '0);
      n_tests++; if (rf_write_addr !== 4'(i) || init_done !== 1'b0) begin
        n_fail++; $display("FAIL clr_resweep[%0d]: got addr=%0d init_done=%b need %0d/0", i, rf_write_addr, init_done, i);
      end
      advance();
    end
    n_tests++; if (init_done !== 1'b1) begin n_fail++; $display("FAIL clr_done: got %b need 1", init_done); end
  endtask

  task test_clear_run();
    int k;
    drive(1'b0, 2'b01, 2'b01, 8'h07, 16'h003C);
    advance();
    drive(1'b0, 2'b10, 2'b00, 8'h70, 16'h0000);
    n_tests++; if (req_ready !== 2'b10) begin n_fail++; $display("FAIL clr_pre_read: got %b need 10", req_ready); end
    advance();
    drive(1'b1, 2'b11, 2'b00, 8'h77, 16'h0000);
    n_tests++; if (req_ready !== 2'b00) begin n_fail++; $display("FAIL clr_ready: got %b need 00", req_ready); end
    n_tests++; if (rsp_valid !== 2'b10 || rsp_rdata !== 8'h3C) begin
      n_fail++; $display("FAIL clr_pending_rsp: got valid=%b data=%h need 10/3c", rsp_valid, rsp_rdata);
    end
    advance();
    n_tests++; if (init_done !== 1'b0) begin n_fail++; $display("FAIL clr_init_low: got %b need 0", init_done); end
    k = 0;
    while (!init_done && k < 40) begin
      drive(1'b0, 2'b01, 2'b00, 8'h07, 16'h0000);
      advance();
      k++;
    end
    n_tests++; if (init_done !== 1'b1) begin n_fail++; $display("FAIL clr_wait: timed out, init_done=%b need 1", init_done); end
    drive(1'b0, 2'b01, 2'b00, 8'h07, 16'h0000);
    n_tests++; if (req_ready !== 2'b01) begin n_fail++; $display("FAIL clr_read_ready: got %b need 01", req_ready); end
    advance();
    n_tests++; if (rsp_valid !== 2'b01 || rsp_rdata !== 8'h00) begin
      n_fail++; $display("FAIL clr_read_zero: got valid=%b data=%h need 01/00", rsp_valid, rsp_rdata);
    end
  endtask

  task test_reset_pending();
    drive(1'b0, 2'b01, 2'b00, 8'h03, 16'h0000);
    n_tests++; if (req_ready !== 2'b01) begin n_fail++; $display("FAIL rstp_accept: got %b need 01", req_ready); end
    #1;
    reset_n = 1'b0;
    model_reset();
    #1;
    n_tests++; if (req_ready !== 2'b00 || rf_write_enable !== 1'b0) begin
      n_fail++; $display("FAIL rstp_gate: got ready=%b we=%b need 00/0", req_ready, rf_write_enable);
    end
    @(negedge clk);
    n_tests++; if (rsp_valid !== 2'b00 || rsp_rdata !== 8'h00) begin
      n_fail++; $display("FAIL rstp_dropped: got valid=%b data=%h need 00/00", rsp_valid, rsp_rdata);
    end
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 2'b00, 2'b00, '0, '0);
      n_tests++; if (rf_write_enable !== 1'b1 || rf_write_addr !== 4'(i) || init_done !== 1'b0) begin
        n_fail++; $display("FAIL rstp_resweep[%0d]: got we=%b addr=%0d init_done=%b need 1/%0d/0",
                           i, rf_write_enable, rf_write_addr, init_done, i);
      end
      advance();
    end
  endtask

  task test_random();
    logic clr;
    for (int c = 0; c < 400; c++) begin
      clr = ($urandom_range(0, 39) == 0);
      drive(clr, 2'($urandom), 2'($urandom), 8'($urandom), 16'($urandom));
      n_tests++; if (req_ready !== e_ready || rf_write_enable !== e_we) begin
        n_fail++; $display("FAIL rnd_ctrl[%0d]: got ready=%b we=%b need %b/%b", c, req_ready, rf_write_enable, e_ready, e_we);
      end
      if (e_we) begin
        n_tests++; if (rf_write_addr !== e_waddr || rf_write_data !== e_wdata) begin
          n_fail++; $display("FAIL rnd_wport[%0d]: got %0d/%h need %0d/%h", c, rf_write_addr, rf_write_data, e_waddr, e_wdata);
        end
      end
      if (e_acc && !req_write[e_g]) begin
        n_tests++; if (rf_read_addr !== req_addr[e_g*AW +: AW]) begin
          n_fail++; $display("FAIL rnd_raddr[%0d]: got %0d need %0d", c, rf_read_addr, req_addr[e_g*AW +: AW]);
        end
      end
      n_tests++; if (rsp_valid !== m_rsp_v || rsp_rdata !== m_rsp_d || init_done !== m_run) begin
        n_fail++; $display("FAIL rnd_rsp[%0d]: got v=%b d=%h done=%b need %b/%h/%b",
                           c, rsp_valid, rsp_rdata, init_done, m_rsp_v, m_rsp_d, m_run);
      end
      advance();
    end
  endtask

  initial begin
    test_reset();
    test_sweep();
    test_write_read();
    test_round_robin();
    test_clear_sweep();
    test_clear_run();
    test_reset_pending();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/regfile_arbiter.md
REGFILE_ARBITER -- requirements
Module: regfile_arbiter

Interface
REQ-001 Parameter DATA_W, default 8, register data width.
REQ-002 Parameter ADDR_W, default 4, register address width; register count is 2**ADDR_W.
REQ-003 clk  input  1  single clock; all state updates on posedge.
REQ-004 reset_n  input  1  reset, asynchronous and active-low.
REQ-005 clear_req  input  1  single-cycle pulse; restarts the zero-fill sweep.
REQ-006 req_valid  input  2  per-requester request valid.
REQ-007 req_write  input  2  per-requester op: 1 = write, 0 = read.
REQ-008 req_addr  input  2*ADDR_W  per-requester address; requester i uses bits [i*ADDR_W +: ADDR_W].
REQ-009 req_wdata  input  2*DATA_W  per-requester write data, packed as req_addr.
REQ-010 req_ready  output  2  per-requester accept; a transfer occurs when valid and ready are both 1.
REQ-011 rsp_valid  output  2  per-requester read response valid, one-cycle pulse.
REQ-012 rsp_rdata  output  DATA_W  read response data, shared by both requesters.
REQ-013 init_done  output  1  high when the zero-fill sweep is complete and requests are accepted.
REQ-014 rf_write_enable, rf_write_addr, rf_write_data  output  1/ADDR_W/DATA_W  register file write port.
REQ-015 rf_read_addr  output  ADDR_W  register file read address.
REQ-016 rf_read_data  input  DATA_W  combinational read data returned for rf_read_addr.

Function
REQ-017 FSM states: INIT and RUN only.
REQ-018 INIT: a counter runs 0..2**ADDR_W-1, one write per cycle, with rf_write_enable=1, rf_write_addr=counter and rf_write_data=0.
REQ-019 After the write to the last address, the FSM moves to RUN on the next edge; init_done=1 in RUN only.
REQ-020 A full sweep takes exactly 2**ADDR_W cycles (16 at default).
REQ-021 req_ready is all-zero in INIT.
REQ-022 At most one request is accepted per cycle across both requesters.
REQ-023 Only one requester valid in RUN: that requester is granted.
REQ-024 Both requesters valid in RUN: the requester named by the 1-bit priority pointer is granted.
REQ-025 After every accepted request, the pointer moves to the non-granted requester (round-robin).
REQ-026 req_ready is combinational from req_valid and the pointer, and is never 1 for a requester whose req_valid is 0.
REQ-027 Accepted write, same cycle: rf_write_enable=1, rf_write_addr/rf_write_data from the granted requester; the register file commits on that edge.
REQ-028 Accepted read in cycle N: rf_read_addr is driven in cycle N, and rf_read_data is registered into rsp_rdata on that edge.
REQ-029 For that read, rsp_valid[granted]=1 in cycle N+1 only; read latency is 1 cycle.
REQ-030 A write accepted in cycle N followed by a read of the same address in N+1 returns the new data.
REQ-031 When no write occurs, rf_write_enable=0; rf_read_addr holds its last value when idle (don't-care for the register file).
REQ-032 clear_req in RUN: the next state is INIT with counter=0, and requests are not accepted in the clear_req cycle.
REQ-033 clear_req in INIT: the counter restarts at 0 on the next edge.
REQ-034 A read accepted in the cycle before clear_req still delivers its rsp_valid pulse.

Reset
REQ-035 While reset_n=0: state=INIT, counter=0, pointer=0 (requester 0 first).
REQ-036 While reset_n=0: rsp_valid=0, rsp_rdata=0, req_ready=0, init_done=0, and rf_write_enable=0 (gated by reset_n).
REQ-037 Reset assertion mid-sweep or mid-transaction aborts immediately, and any pending response is dropped.
REQ-038 After reset_n rises, the sweep starts on the first clock edge.

Verification
REQ-039 Release reset, no requests -> 16 consecutive writes of 0 to addr 0..15; init_done rises in cycle 17.
REQ-040 RUN, req0 write addr 3 data 0xA5, then next cycle req0 read addr 3 -> rsp_valid[0] pulses one cycle later with rsp_rdata=0xA5.
REQ-041 Both requesters hold valid reads (addr 1, addr 2) for 4 cycles from reset pointer -> grants 0,1,0,1 and rsp_valid alternates accordingly.
REQ-042 clear_req at sweep cycle 8 -> counter returns to 0; init_done delayed to 16 cycles after the clear.
REQ-043 Write 0x3C to addr 7, pulse clear_req, wait for init_done, read addr 7 -> rsp_rdata=0x00.
REQ-044 reset_n dropped while rsp_valid is pending -> rsp_valid stays 0, and the sweep restarts after release.
